intadd_sched: RTL

INTADD_SCHED -- requirements
Module: intadd_sched

---
 rtl/intadd_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/intadd_sched.sv
// intadd_sched -- schedules operations from two requesters onto one shared
// intadd unit, keeping exactly one operation in flight
// (IDLE -> ISSUE -> WAIT -> RESP -> IDLE).
// Build option: define INTADD_SCHED_RR_EN for round-robin arbitration;
// without it req0 has fixed priority over req1 and no pointer exists.
//
// Handshake rules: a request transfers on a rising clk edge where reqN_valid
// and reqN_ready are both 1. reqN_ready is combinational on the valids and is
// only ever 1 in IDLE for the arbitration winner. A requester holds valid and
// payload until that edge. A response is presented with rsp_valid and holds
// rsp_id/rsp_* stable until an edge where rsp_valid & rsp_ready are both 1.
module intadd_sched #(
    parameter int RES_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_src0,
    input  logic [127:0] req0_src1,
    input  logic [127:0] req0_src2,
    input  logic [9:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_src0,
    input  logic [127:0] req1_src1,
    input  logic [127:0] req1_src2,
    input  logic [9:0]   req1_ctrl,
    output logic [10:0]  cru_intadd,
    output logic [127:0] src_reg0,
    output logic [127:0] src_reg1,
    output logic [127:0] src_reg2,
    input  logic [127:0] dst_reg0,
    input  logic [127:0] dst_reg1,
    input  logic [127:0] st,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_dst0,
    output logic [127:0] rsp_dst1,
    output logic [127:0] rsp_st,
    output logic [1:0]   state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0] state_q;
    logic [2:0] cnt_q;
    logic [9:0] ctrl_q;
    logic       id_q;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       capture;

`ifdef INTADD_SCHED_RR_EN
    logic ptr_q;

    // Round-robin: on contention the pointer's requester wins
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
        end
    end

    // After every acceptance the pointer moves to the requester not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= grant0;
        end
    end
`else
    // Fixed priority: req0 always beats req1
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    // Readies only in IDLE; gated by rst_n so they drop the moment reset asserts
    always_comb begin
        req0_ready = rst_n & (state_q == S_IDLE) & grant0;
        req1_ready = rst_n & (state_q == S_IDLE) & grant1;
    end

    assign accept     = req0_ready | req1_ready;
    assign capture    = (state_q == S_WAIT) && (cnt_q == 3'd0);
    assign cru_intadd = {state_q == S_ISSUE, ctrl_q};
    assign rsp_valid  = (state_q == S_RESP);
    assign state_dbg  = state_q;

    // Sequencer plus the WAIT latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_q <= S_ISSUE;
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= 3'(RES_LAT - 1);
                end
                S_WAIT:  begin
                    if (cnt_q == 3'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                S_RESP:  if (rsp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register the winner's operands, control and id on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg0 <= '0;
            src_reg1 <= '0;
            src_reg2 <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
        end else if (accept) begin
            src_reg0 <= grant1 ? req1_src0 : req0_src0;
            src_reg1 <= grant1 ? req1_src1 : req0_src1;
            src_reg2 <= grant1 ? req1_src2 : req0_src2;
            ctrl_q   <= grant1 ? req1_ctrl : req0_ctrl;
            id_q     <= grant1;
        end
    end

    // Capture the unit's results when the latency counter expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_dst0 <= '0;
            rsp_dst1 <= '0;
            rsp_st   <= '0;
            rsp_id   <= 1'b0;
        end else if (capture) begin
            rsp_dst0 <= dst_reg0;
            rsp_dst1 <= dst_reg1;
            rsp_st   <= st;
            rsp_id   <= id_q;
        end
    end

endmodule
